// File: rtl/adder_serial_ctrl.sv
// -----------------------------------------------------------------------------
// adder_serial_ctrl
//   Bit-serial adder with a valid/ready request side and a valid/ready result
//   side. Each request is processed LSB first, one bit per clock, on a
//   single shared 1-bit full-add datapath. The block holds the result until
//   the consumer takes it.
//
//   Parameters
//     WIDTH      operand/result width, 1..64
//
//   Ports
//     i_clk      clock; all state updates on the rising edge
//     i_rst      synchronous active-high reset
//     i_valid    request strobe, operands valid (looked at only in IDLE)
//     o_ready    high in IDLE: a request can be accepted
//     i_num_a    operand A
//     i_num_b    operand B
//     o_valid    high in DONE: result available
//     i_ready    consumer takes the result (looked at only in DONE)
//     o_res      sum A+B modulo 2^WIDTH
//     o_cry      carry out of bit WIDTH-1
//     o_busy     high while the serial add is running
//     o_ovf      signed overflow; present only when ADDER_SERIAL_OVF_EN
//                is defined
//
//   Optional feature macro: ADDER_SERIAL_OVF_EN
// -----------------------------------------------------------------------------
module adder_serial_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_num_a,
    input  logic [WIDTH-1:0] i_num_b,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_res,
    output logic             o_cry,
    output logic             o_busy
`ifdef ADDER_SERIAL_OVF_EN
    ,
    output logic             o_ovf
`endif
);

    // Counter must be at least one bit wide even when WIDTH=1.
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               c_q, c_d;
    logic               cry_q, cry_d;
`ifdef ADDER_SERIAL_OVF_EN
    logic               ovf_q, ovf_d;
`endif

    // Shared 1-bit datapath: two cascaded half-add steps plus an OR.
    logic half_sum;
    logic sum_bit;
    logic carry_nxt;

    always_comb begin
        half_sum  = a_q[0] ^ b_q[0];
        sum_bit   = half_sum ^ c_q;
        carry_nxt = (a_q[0] & b_q[0]) | (c_q & half_sum);
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        cry_d   = cry_q;
`ifdef ADDER_SERIAL_OVF_EN
        ovf_d   = ovf_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (i_valid) begin
                    a_d     = i_num_a;
                    b_d     = i_num_b;
                    c_d     = 1'b0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                c_d   = carry_nxt;
                // Sum bits enter at the MSB so after WIDTH shifts bit 0
                // of the result sits at res[0].
                res_d = (res_q >> 1) | (WIDTH'(sum_bit) << (WIDTH - 1));
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    cry_d   = carry_nxt;
`ifdef ADDER_SERIAL_OVF_EN
                    // c_q is the carry into the MSB on this last step.
                    ovf_d   = c_q ^ carry_nxt;
`endif
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (i_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            cry_q   <= 1'b0;
`ifdef ADDER_SERIAL_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            cry_q   <= cry_d;
`ifdef ADDER_SERIAL_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    always_comb begin
        o_ready = (state_q == IDLE);
        o_busy  = (state_q == RUN);
        o_valid = (state_q == DONE);
        o_res   = res_q;
        o_cry   = cry_q;
`ifdef ADDER_SERIAL_OVF_EN
        o_ovf   = ovf_q;
`endif
    end

endmodule

// File: doc/adder_serial_ctrl.md
ADDER_SERIAL_CTRL -- requirements
Module: adder_serial_ctrl

Interface
REQ-001 SHALL have parameter: WIDTH, default 8, operand/result width in bits; legal range 1..64.
REQ-002 SHALL have port: i_clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: i_rst  input  1  reset; synchronous and active-high.
REQ-004 SHALL have port: i_valid  input  1  request strobe; operands valid.
REQ-005 SHALL have port: o_ready  output  1  controller can accept a request.
REQ-006 SHALL have port: i_num_a  input  WIDTH  operand A, unsigned/two's complement.
REQ-007 SHALL have port: i_num_b  input  WIDTH  operand B.
REQ-008 SHALL have port: o_valid  output  1  result available.
REQ-009 SHALL have port: i_ready  input  1  consumer accepts result.
REQ-010 SHALL have port: o_res  output  WIDTH  sum A+B modulo 2^WIDTH.
REQ-011 SHALL have port: o_cry  output  1  carry out of bit WIDTH-1.
REQ-012 SHALL have port: o_busy  output  1  high while state is RUN.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-014 SHALL drive o_ready=1 only in IDLE, o_valid=1 only in DONE, o_busy=1 only in RUN.
REQ-015 SHALL accept a request on an edge where state=IDLE and i_valid=1: latch i_num_a and i_num_b into shift registers, clear carry register, clear bit counter, go to RUN.
REQ-016 SHALL, each RUN cycle, form sum bit = a[0]^b[0]^c and next carry = (a[0]&b[0])|(c&(a[0]^b[0])), i.e. two cascaded half-add steps plus OR on one shared 1-bit datapath.
REQ-017 SHALL shift the sum bit into o_res from the MSB side and shift both operand registers right by one per RUN cycle, processing LSB first.
REQ-018 SHALL remain in RUN for exactly WIDTH cycles, then enter DONE; o_valid rises in the cycle WIDTH+1 clocks after the accept edge.
REQ-019 SHALL hold o_res and o_cry stable throughout DONE until i_ready=1 is sampled, then return to IDLE.
REQ-020 SHALL NOT accept a new request in the same edge that retires a result; o_ready rises the cycle after retirement.
REQ-021 SHALL ignore i_valid, i_num_a, i_num_b in RUN and DONE.
REQ-022 SHALL ignore i_ready outside DONE.
REQ-023 SHALL retain the last o_res/o_cry values in IDLE after retirement until the next accept.
REQ-024 SHALL, with WIDTH=1, spend exactly one RUN cycle.

Reset
REQ-025 SHALL, with i_rst=1 on an edge, force state IDLE, o_res=0, o_cry=0, carry=0, counter=0, operand registers=0, regardless of current state.
REQ-026 SHALL abort any operation in RUN or DONE on reset with no result ever presented.
REQ-027 SHALL give reset priority over i_valid and i_ready on the same edge.

Configuration
REQ-028 SHALL, when macro ADDER_SERIAL_OVF_EN is defined, add port o_ovf  output  1, equal to signed overflow (carry into bit WIDTH-1 XOR carry out), registered with o_res, reset 0, held in DONE like o_res.
REQ-029 SHALL, when ADDER_SERIAL_OVF_EN is undefined, omit o_ovf and its logic entirely; all other behaviour unchanged.

Verification
REQ-030 SHALL cover, WIDTH=8: A=0x03, B=0x05 -> o_valid 9 cycles after accept, o_res=0x08, o_cry=0.
REQ-031 SHALL cover: A=0xFF, B=0x01 -> o_res=0x00, o_cry=1, o_ovf=0 (macro defined).
REQ-032 SHALL cover: A=0x7F, B=0x01 -> o_res=0x80, o_cry=0, o_ovf=1; A=0x80, B=0x80 -> o_res=0x00, o_cry=1, o_ovf=1.
REQ-033 SHALL cover: i_ready=0 for 5 cycles in DONE -> o_valid, o_res held constant; i_ready=1 -> IDLE next cycle, o_ready=1 the cycle after retirement.
REQ-034 SHALL cover: i_valid=1 with A=0xAA, B=0x55 during RUN -> ignored, in-flight result unchanged; i_rst=1 at RUN cycle 4 -> IDLE, o_res=0, o_valid never asserted.
